// File: rtl/relay_rr_arbiter.sv
// Round-robin arbiter that shares one two-phase relay stage between N two-phase requesters.
// Handshake inputs are double-synchronised and every output is registered.
module relay_rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     inR,
    output logic [N-1:0]     inA,
    output logic             outR,
    input  logic             outA,
    output logic [SEL_W-1:0] sel,
    output logic             fire,
    output logic             busy,
    output logic             err
);

    localparam int IDX_W = SEL_W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arbState_e;

    logic [N-1:0]     inRMeta_r;
    logic [N-1:0]     inR_s;
    logic             outAMeta_r;
    logic             outA_s;

    arbState_e        state_r;
    arbState_e        stateNext_s;
    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] ptrNext_s;
    logic [SEL_W-1:0] sel_r;
    logic [SEL_W-1:0] selNext_s;
    logic             outR_r;
    logic             outRNext_s;
    logic [N-1:0]     inA_r;
    logic [N-1:0]     inANext_s;
    logic             fire_r;
    logic             fireNext_s;
    logic             busy_r;
    logic             busyNext_s;
    logic             err_r;
    logic             errNext_s;

    logic [N-1:0]     pending_s;
    logic             anyPending_s;
    logic [SEL_W-1:0] winner_s;
    logic [IDX_W-1:0] idx_s;
    logic [SEL_W-1:0] selInc_s;
    logic [N-1:0]     grantMask_s;

    // Two-flop synchronisers for the asynchronous handshake inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inRMeta_r  <= {N{1'b0}};
            inR_s      <= {N{1'b0}};
            outAMeta_r <= 1'b0;
            outA_s     <= 1'b0;
        end else begin
            inRMeta_r  <= inR;
            inR_s      <= inRMeta_r;
            outAMeta_r <= outA;
            outA_s     <= outAMeta_r;
        end
    end

    assign pending_s   = inR_s ^ inA_r;
    assign selInc_s    = (sel_r == SEL_W'(N - 1)) ? {SEL_W{1'b0}} : sel_r + SEL_W'(1);
    assign grantMask_s = {{(N-1){1'b0}}, 1'b1} << sel_r;

    // Round-robin search: first pending requester starting at ptr, wrapping modulo N
    always_comb begin
        anyPending_s = 1'b0;
        winner_s     = {SEL_W{1'b0}};
        idx_s        = {IDX_W{1'b0}};
        for (int k = 0; k < N; k++) begin
            idx_s = {1'b0, ptr_r} + IDX_W'(k);
            idx_s = (idx_s >= IDX_W'(N)) ? idx_s - IDX_W'(N) : idx_s;
            winner_s = (!anyPending_s && pending_s[idx_s[SEL_W-1:0]]) ? idx_s[SEL_W-1:0] : winner_s;
            anyPending_s = anyPending_s | pending_s[idx_s[SEL_W-1:0]];
        end
    end

    // Next-state and next-output logic for the grant/wait handshake
    always_comb begin
        stateNext_s = state_r;
        ptrNext_s   = ptr_r;
        selNext_s   = sel_r;
        outRNext_s  = outR_r;
        inANext_s   = inA_r;
        fireNext_s  = 1'b0;
        busyNext_s  = busy_r;
        errNext_s   = err_r;
        case (state_r)
            IDLE: begin
                // An acknowledge phase change with nothing outstanding is a protocol error
                if (outA_s != outR_r) begin
                    errNext_s = 1'b1;
                end else begin
                    errNext_s = err_r;
                end
                if (anyPending_s) begin
                    selNext_s   = winner_s;
                    outRNext_s  = ~outR_r;
                    fireNext_s  = 1'b1;
                    busyNext_s  = 1'b1;
                    stateNext_s = WAIT;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            WAIT: begin
                if (outA_s == outR_r) begin
                    inANext_s   = inA_r ^ grantMask_s;
                    ptrNext_s   = selInc_s;
                    busyNext_s  = 1'b0;
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = WAIT;
                end
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= {SEL_W{1'b0}};
            sel_r   <= {SEL_W{1'b0}};
            outR_r  <= 1'b0;
            inA_r   <= {N{1'b0}};
            fire_r  <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= stateNext_s;
            ptr_r   <= ptrNext_s;
            sel_r   <= selNext_s;
            outR_r  <= outRNext_s;
            inA_r   <= inANext_s;
            fire_r  <= fireNext_s;
            busy_r  <= busyNext_s;
            err_r   <= errNext_s;
        end
    end

    assign inA  = inA_r;
    assign outR = outR_r;
    assign sel  = sel_r;
    assign fire = fire_r;
    assign busy = busy_r;
    assign err  = err_r;

endmodule

// File: tb/tb_relay_rr_arbiter.sv
// Directed bench for relay_rr_arbiter: a transaction-level model of the arbitration rules
// is stepped every rising edge and compared with the DUT, plus literal expectations.
module tb_relay_rr_arbiter;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     inR;
    logic [N-1:0]     inA;
    logic             outR;
    logic             outA;
    logic [SEL_W-1:0] sel;
    logic             fire;
    logic             busy;
    logic             err;

    relay_rr_arbiter #(.N(N), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .inR (inR),
        .inA (inA),
        .outR(outR),
        .outA(outA),
        .sel (sel),
        .fire(fire),
        .busy(busy),
        .err (err)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int fireCount = 0;
    int gLog[$];

    // model: inputs as seen through a two-edge delay, plus the transaction in flight
    logic [N-1:0] hR1, hR2;
    logic         hA1, hA2;
    int           mSel, mPtr;
    logic         mOutR, mFire, mBusy, mErr;
    logic [N-1:0] mInA;

    // environment: shared-stage responder and re-requesting requesters
    logic         autoAck;
    logic         lastOutR;
    int           ackCnt;
    logic [N-1:0] reMask, prevInA;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelStep();
        logic [N-1:0] sR;
        logic         sA;
        int           idx;
        bit           found;
        if (rst) begin
            hR1 = '0; hR2 = '0; hA1 = 1'b0; hA2 = 1'b0;
            mSel = 0; mPtr = 0; mOutR = 1'b0; mFire = 1'b0; mBusy = 1'b0; mErr = 1'b0;
            mInA = '0;
        end else begin
            sR = hR2; sA = hA2;
            hR2 = hR1; hR1 = inR; hA2 = hA1; hA1 = outA;
            mFire = 1'b0;
            if (!mBusy) begin
                if (sA != mOutR) mErr = 1'b1;
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx = (mPtr + k) % N;
                    if (!found && (sR[idx] != mInA[idx])) begin
                        found = 1'b1;
                        mSel  = idx;
                    end
                end
                if (found) begin
                    mOutR = ~mOutR;
                    mFire = 1'b1;
                    mBusy = 1'b1;
                end
            end else if (sA == mOutR) begin
                mInA[mSel] = ~mInA[mSel];
                mPtr  = (mSel + 1) % N;
                mBusy = 1'b0;
            end
        end
    endtask

    task automatic compareAll();
        check("outR", int'(outR), int'(mOutR));
        check("inA",  int'(inA),  int'(mInA));
        check("sel",  int'(sel),  mSel);
        check("fire", int'(fire), int'(mFire));
        check("busy", int'(busy), int'(mBusy));
        check("err",  int'(err),  int'(mErr));
        if (fire) begin
            fireCount++;
            gLog.push_back(int'(sel));
        end
    endtask

    task automatic envDrive();
        if (autoAck) begin
            if (outR != lastOutR) begin
                lastOutR = outR;
                ackCnt   = 2;
            end else if (ackCnt > 0) begin
                ackCnt--;
                if (ackCnt == 0) outA = ~outA;
            end
        end else begin
            lastOutR = outR;
            ackCnt   = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (reMask[i] && (inA[i] != prevInA[i])) inR[i] = ~inR[i];
        end
        prevInA = inA;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
        @(negedge clk);
        envDrive();
    endtask

    function automatic int logAt(input int i);
        return (i < gLog.size()) ? gLog[i] : -1;
    endfunction

    int s;
    int f0;

    initial begin
        rst = 1'b1; inR = '0; outA = 1'b0;
        autoAck = 1'b0; lastOutR = 1'b0; ackCnt = 0; reMask = '0; prevInA = '0;
        hR1 = '0; hR2 = '0; hA1 = 1'b0; hA2 = 1'b0;
        mSel = 0; mPtr = 0; mOutR = 1'b0; mFire = 1'b0; mBusy = 1'b0; mErr = 1'b0; mInA = '0;
        repeat (3) tick();
        check("rst_outR", int'(outR), 0);
        check("rst_inA",  int'(inA),  0);
        check("rst_busy", int'(busy), 0);

        // single request: grant at edge 2, ack before edge 5 completes at edge 7
        rst = 1'b0; inR = 4'b0001;
        repeat (3) tick();
        check("t1_outR", int'(outR), 1);
        check("t1_fire", int'(fire), 1);
        check("t1_sel",  int'(sel),  0);
        check("t1_busy", int'(busy), 1);
        repeat (2) tick();
        outA = 1'b1;
        repeat (2) tick();
        check("t1_inA_e6",  int'(inA),  0);
        check("t1_busy_e6", int'(busy), 1);
        tick();
        check("t1_inA_e7",  int'(inA),  1);
        check("t1_busy_e7", int'(busy), 0);

        // all four request together from ptr 0
        rst = 1'b1; inR = '0; outA = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        s = gLog.size();
        inR = 4'b1111; autoAck = 1'b1;
        repeat (45) tick();
        check("t2_ngrants", gLog.size() - s, 4);
        for (int k = 0; k < 4; k++) check("t2_order", logAt(s + k), k);
        check("t2_inA", int'(inA), 'hF);
        inR = inR ^ 4'b1001;
        repeat (25) tick();
        check("t2_ptr0_first", logAt(s + 4), 0);
        check("t2_then3",      logAt(s + 5), 3);
        check("t2_inA_b",      int'(inA), 'h6);

        // requesters 1 and 2 re-request immediately; grants must alternate
        s = gLog.size();
        reMask = 4'b0110; inR = inR ^ 4'b0110;
        repeat (60) tick();
        reMask = '0;
        repeat (30) tick();
        for (int k = 0; k < 6; k++) check("t3_alt", logAt(s + k), (k % 2 == 0) ? 1 : 2);

        // spurious acknowledge sets a sticky error
        autoAck = 1'b0;
        repeat (5) tick();
        check("t4_err_clear", int'(err), 0);
        outA = ~outA;
        repeat (3) tick();
        check("t4_err_set", int'(err), 1);
        inR[0] = ~inR[0]; autoAck = 1'b1;
        repeat (25) tick();
        check("t4_err_sticky", int'(err), 1);
        autoAck = 1'b0;

        // reset during WAIT with sel 3
        rst = 1'b1; inR = '0; outA = 1'b0;
        repeat (2) tick();
        rst = 1'b0; inR = 4'b1000;
        repeat (4) tick();
        check("t5_sel3",  int'(sel),  3);
        check("t5_busy",  int'(busy), 1);
        rst = 1'b1; inR = '0; outA = 1'b0;
        #1;
        check("t5_rst_outR", int'(outR), 0);
        check("t5_rst_inA",  int'(inA),  0);
        check("t5_rst_sel",  int'(sel),  0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_fire", int'(fire), 0);
        check("t5_rst_err",  int'(err),  0);
        tick();
        rst = 1'b0;
        f0 = fireCount;
        repeat (8) tick();
        check("t5_no_fire", fireCount - f0, 0);
        inR = 4'b0100;
        repeat (3) tick();
        check("t5_new_fire", int'(fire), 1);
        check("t5_new_sel",  int'(sel),  2);
        outA = 1'b1;
        repeat (8) tick();
        check("t5_inA",  int'(inA),  'h4);
        check("t5_idle", int'(busy), 0);

        // requester 1 glitches twice within a cycle, requester 3 toggles twice, both during WAIT
        s = gLog.size();
        inR[0] = ~inR[0];
        repeat (4) tick();
        check("t6_sel0", int'(sel),  0);
        check("t6_busy", int'(busy), 1);
        inR[1] = ~inR[1];
        #2;
        inR[1] = ~inR[1];
        inR[3] = ~inR[3];
        repeat (2) tick();
        inR[3] = ~inR[3];
        repeat (3) tick();
        outA = ~outA;
        repeat (10) tick();
        check("t6_inA",     int'(inA), 'h5);
        check("t6_ngrants", gLog.size() - s, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
